serial_sub_nbit: RTL and testbench
==================================

// Module: serial_sub_nbit
// PURPOSE
//  Bit-serial N-bit subtractor: computes diff = a - b - bin, one bit per clock,
//  LSB first, through a single 1-bit full-subtractor cell and a borrow flop.
//  Sits directly upstream of, and drives, the 1-bit full-subtractor cell.
//  Trades latency (WIDTH cycles) for area in the subtractor datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk    in   1      single clock; all state updates on rising edge
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      request; sampled only when busy=0
//  a      in   WIDTH  minuend; captured on the edge where start is accepted
//  b      in   WIDTH  subtrahend; captured on the same edge
//  bin    in   1      borrow-in; captured on the same edge
//  busy   out  1      operation in progress
//  done   out  1      one-cycle pulse: diff/bout/ovf just updated
//  diff   out  WIDTH  result a - b - bin, mod 2^WIDTH; held until next done
//  bout   out  1      final borrow out (unsigned a < b + bin)
//  ovf    out  1      two's-complement overflow of a - b - bin
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0.
//   Internal shift regs, bit counter and borrow flop cleared.
//   Reset mid-operation aborts it; no done pulse and no result update follow.
//  FSM: IDLE -> SHIFT when start=1 at an edge with busy=0 (capture edge E0).
//   SHIFT -> IDLE at edge E_WIDTH, after the last bit has been processed.
//  E0: a_sr<=a, b_sr<=b, brw<=bin, cnt<=0, a_msb<=a[WIDTH-1],
//   b_msb<=b[WIDTH-1], busy<=1.
//  Edge E(i+1), i=0..WIDTH-1: cell inputs (a_sr[0], b_sr[0], brw).
//   d = a0^b0^brw;  brw <= (~a0&b0) | (~(a0^b0)&brw).
//   d_sr <= {d, d_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1; cnt <= cnt+1.
//  Edge E_WIDTH: diff <= final d_sr (includes bit WIDTH-1); bout <= final brw;
//   ovf <= (a_msb != b_msb) && (diff[WIDTH-1] != a_msb); done <= 1; busy <= 0.
//  Latency: done is high in the cycle after E_WIDTH, exactly WIDTH edges after
//   E0. done clears on the following edge.
//  start while busy=1: ignored; no queueing, no effect on the running operation.
//  start during the done cycle (busy=0): accepted, so back-to-back operations
//   run with no idle cycle. done still drops at that edge; diff/bout/ovf hold
//   until the next done.
//  cnt width is $clog2(WIDTH); the last bit is processed when cnt==WIDTH-1
//   (no wrap-around beyond that).
//  diff/bout/ovf never change except at the done-producing edge or at reset.
// STRUCTURE
//  Shared package: FSM state encoding (ST_IDLE, ST_SHIFT) and the
//   DEFAULT_WIDTH constant.
//  One sub-module, fs_cell_1bit: the combinational 1-bit full-subtractor
//   (x, y, bin -> diff, bout), instantiated once.
//  Top level holds the FSM, counter, shift registers, borrow flop and
//   output registers.
// TESTING
//  WIDTH=8: a=100, b=37, bin=0 -> done 8 cycles after E0; diff=63, bout=0, ovf=0.
//  a=5, b=9, bin=0 -> diff=8'hFC, bout=1, ovf=0.
//  a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0, ovf=1.
//   Also a=8'h7F, b=8'hFF -> diff=8'h80, bout=1, ovf=1.
//  a=0, b=0, bin=1 -> diff=8'hFF, bout=1, ovf=0.
//   Then a second start in the done cycle (a=3, b=1) -> diff=2 after 8 more cycles.
//  start re-pulsed with new operands while busy -> ignored; result matches the
//   first operands. rst_n low at cycle 4 of an op -> all outputs 0, no done.
//  WIDTH=4: exhaustive a, b, bin (512 cases) vs model {bout,diff} = a-b-bin
//   (5-bit); check ovf and the done timing on every case.

Source files
------------

// File: rtl/serial_sub_nbit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_nbit_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_nbit_if.sv
// Request/result bundle between a requester and the bit-serial subtractor.
interface serial_sub_nbit_if #(
  parameter int WIDTH = serial_sub_nbit_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_sub_nbit_fs_cell_1bit.sv
// Combinational 1-bit full subtractor: diff = x - y - bin, with borrow out.
module fs_cell_1bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_sub_nbit.sv
// Bit-serial subtractor: one bit per clock, LSB first, through a single
// full-subtractor cell and a borrow flop; result registered on completion.
module serial_sub_nbit
  import serial_sub_nbit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  serial_sub_nbit_if.slave bus
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic cell_d, cell_bo;

  fs_cell_1bit u_cell (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (brw_q),
    .diff (cell_d),
    .bout (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_sr_d  = d_sr_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          brw_d   = bus.bin;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        brw_d  = cell_bo;
        d_sr_d = {cell_d, d_sr_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          // cell_d is the result MSB on this edge, so overflow needs no extra cycle
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = {cell_d, d_sr_q[WIDTH-1:1]};
          bout_d  = cell_bo;
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_sr_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_sr_q  <= d_sr_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Directed + random + exhaustive (WIDTH=4) checks of the bit-serial subtractor
// against an integer-arithmetic reference.
module tb_serial_sub_nbit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_sub_nbit_if #(.WIDTH(8)) i8 ();
  serial_sub_nbit_if #(.WIDTH(4)) i4 ();

  serial_sub_nbit #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  serial_sub_nbit #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction; ovf from operand/result sign bits.
  function automatic void model(input int w, input int a, input int b, input int bin,
                                output int d, output int bo, output int ov);
    int r;
    r  = a - b - bin;
    bo = (r < 0) ? 1 : 0;
    d  = r & ((1 << w) - 1);
    ov = ((((a >> (w-1)) & 1) != ((b >> (w-1)) & 1)) &&
          (((d >> (w-1)) & 1) != ((a >> (w-1)) & 1))) ? 1 : 0;
  endfunction

  // Called at a negedge; returns at the negedge just after the capture edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    i8.start = 1'b1; i8.a = a; i8.b = b; i8.bin = bin;
    @(posedge clk);
    @(negedge clk);
    i8.start = 1'b0; i8.a = $urandom; i8.b = $urandom; i8.bin = 1'b0;
  endtask

  // n0 = edges already elapsed since the capture edge. Returns in the done cycle.
  task automatic wait8(input int n0, input int a, input int b, input int bin, input string tag);
    int n, d, bo, ov;
    n = n0;
    while (!i8.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    model(8, a, b, bin, d, bo, ov);
    chk({tag, ".lat"},  n, 8);
    chk({tag, ".done"}, i8.done, 1);
    chk({tag, ".busy"}, i8.busy, 0);
    chk({tag, ".diff"}, i8.diff, d);
    chk({tag, ".bout"}, i8.bout, bo);
    chk({tag, ".ovf"},  i8.ovf, ov);
  endtask

  task automatic op8(input int a, input int b, input int bin, input string tag);
    start8(8'(a), 8'(b), 1'(bin));
    chk({tag, ".busy1"}, i8.busy, 1);
    wait8(0, a, b, bin, tag);
    @(negedge clk);
    chk({tag, ".drop"}, i8.done, 0);
  endtask

  task automatic op4(input int a, input int b, input int bin);
    int n, d, bo, ov;
    i4.start = 1'b1; i4.a = 4'(a); i4.b = 4'(b); i4.bin = 1'(bin);
    @(posedge clk);
    @(negedge clk);
    i4.start = 1'b0;
    n = 0;
    while (!i4.done && n < 12) begin
      @(negedge clk);
      n++;
    end
    model(4, a, b, bin, d, bo, ov);
    chk($sformatf("w4 %0d-%0d-%0d lat", a, b, bin), n, 4);
    chk($sformatf("w4 %0d-%0d-%0d res", a, b, bin), {i4.ovf, i4.bout, i4.diff}, {ov[0], bo[0], d[3:0]});
  endtask

  initial begin
    int d, bo, ov, pulses;
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.bin = 1'b0;
    i4.start = 1'b0; i4.a = '0; i4.b = '0; i4.bin = 1'b0;

    #12;
    chk("rst.busy", i8.busy, 0);
    chk("rst.done", i8.done, 0);
    chk("rst.res",  {i8.ovf, i8.bout, i8.diff}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op8(100, 37, 0, "100-37");
    op8(5, 9, 0, "5-9");
    op8(8'h80, 8'h01, 0, "80-01");
    op8(8'h7F, 8'hFF, 0, "7F-FF");

    // Back-to-back: second start lands in the done cycle of the first.
    start8(8'h00, 8'h00, 1'b1);
    wait8(0, 0, 0, 1, "0-0-1");
    start8(8'd3, 8'd1, 1'b0);
    chk("b2b.drop", i8.done, 0);
    chk("b2b.busy", i8.busy, 1);
    chk("b2b.hold", {i8.ovf, i8.bout, i8.diff}, {1'b0, 1'b1, 8'hFF});
    wait8(0, 3, 1, 0, "b2b 3-1");
    @(negedge clk);

    // Start re-pulsed while busy must be ignored.
    start8(8'd200, 8'd17, 1'b1);
    @(negedge clk);
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'd1; i8.b = 8'd250; i8.bin = 1'b0;
    @(negedge clk);
    i8.start = 1'b0;
    wait8(3, 200, 17, 1, "ignore");
    @(negedge clk);

    for (int k = 0; k < 30; k++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(255, 0));
      rb = int'($urandom_range(255, 0));
      rc = int'($urandom_range(1, 0));
      op8(ra, rb, rc, $sformatf("rnd%0d", k));
    end

    // Reset in cycle 4 of an op: outputs clear, no done follows.
    start8(8'd9, 8'd4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", i8.busy, 0);
    chk("midrst.res",  {i8.done, i8.ovf, i8.bout, i8.diff}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (i8.done || i8.busy) pulses++;
    end
    chk("midrst.nodone", pulses, 0);
    chk("midrst.hold", {i8.ovf, i8.bout, i8.diff}, 0);
    op8(64, 65, 0, "post-rst");

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          op4(a, b, c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
